// File: rtl/md_rx_source.sv
// MD RX initiator: buffers upstream requests in a small FIFO and presents
// them on the MD RX port with valid/field hold-until-ready semantics.
// Completed transfers and responder errors are counted for status readout.
module md_rx_source #(
    parameter int ALGN_DATA_WIDTH = 32,
    parameter int BUS_BYTES       = ALGN_DATA_WIDTH / 8,
    parameter int OFFSET_W        = (BUS_BYTES > 1) ? $clog2(BUS_BYTES) : 1,
    parameter int SIZE_W          = $clog2(BUS_BYTES) + 1,
    parameter int FIFO_DEPTH      = 4,
    parameter int CNT_W           = 16
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       req_valid,
    output logic                       req_ready,
    input  logic [ALGN_DATA_WIDTH-1:0] req_data,
    input  logic [OFFSET_W-1:0]        req_offset,
    input  logic [SIZE_W-1:0]          req_size,
    output logic                       md_rx_valid,
    output logic [ALGN_DATA_WIDTH-1:0] md_rx_data,
    output logic [OFFSET_W-1:0]        md_rx_offset,
    output logic [SIZE_W-1:0]          md_rx_size,
    input  logic                       md_rx_ready,
    input  logic                       md_rx_err,
    input  logic                       clr_cnt,
    output logic [CNT_W-1:0]           xfer_cnt,
    output logic [CNT_W-1:0]           err_cnt,
    output logic                       proto_viol,
    output logic                       idle
);

    localparam int AW = $clog2(FIFO_DEPTH);

    typedef struct packed {
        logic [ALGN_DATA_WIDTH-1:0] data;
        logic [OFFSET_W-1:0]        offset;
        logic [SIZE_W-1:0]          size;
    } req_t;

    req_t        mem [FIFO_DEPTH];
    logic [AW:0] wr_ptr, rd_ptr;   // extra MSB separates full from empty
    logic        rdy_en;           // holds req_ready low until the first edge after reset
    logic        fifo_full, fifo_empty;
    logic        push, pop, xfer_done;
    req_t        stage;
    logic        stage_vld;

    assign fifo_empty = (wr_ptr == rd_ptr);
    assign fifo_full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

    // req_ready only depends on registered state, so no path from req_valid
    assign req_ready = rdy_en && !fifo_full;
    assign push      = req_valid && req_ready;
    assign xfer_done = stage_vld && md_rx_ready;
    // stage refills when empty or when its current transfer leaves this edge
    assign pop       = !fifo_empty && (!stage_vld || xfer_done);

    assign md_rx_valid  = stage_vld;
    assign md_rx_data   = stage.data;
    assign md_rx_offset = stage.offset;
    assign md_rx_size   = stage.size;
    assign idle         = fifo_empty && !stage_vld;

    // ready enable comes up one edge after reset release
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) rdy_en <= 1'b0;
        else          rdy_en <= 1'b1;
    end

    // FIFO storage; contents are don't-care while the pointers say empty
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr[AW-1:0]] <= '{data: req_data, offset: req_offset, size: req_size};
    end

    // FIFO pointers, wrapping modulo FIFO_DEPTH in the low bits
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // output stage: load from FIFO head, hold while stalled, drop after last completion
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stage_vld <= 1'b0;
            stage     <= '0;
        end else if (pop) begin
            stage_vld <= 1'b1;
            stage     <= mem[rd_ptr[AW-1:0]];
        end else if (xfer_done) begin
            stage_vld <= 1'b0;
        end
    end

    // saturating statistics; clear wins over any same-cycle update
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            xfer_cnt   <= '0;
            err_cnt    <= '0;
            proto_viol <= 1'b0;
        end else if (clr_cnt) begin
            xfer_cnt   <= '0;
            err_cnt    <= '0;
            proto_viol <= 1'b0;
        end else begin
            if (xfer_done && (xfer_cnt != '1))             xfer_cnt <= xfer_cnt + 1'b1;
            if (xfer_done && md_rx_err && (err_cnt != '1)) err_cnt  <= err_cnt + 1'b1;
            if (md_rx_err && !xfer_done)                   proto_viol <= 1'b1;
        end
    end

endmodule

// File: tb/tb_md_rx_source.sv
// Bench for md_rx_source: directed scenario tasks plus a randomized run,
// all observed by a negedge scoreboard that tracks expected transfers
// and statistics from the protocol rules.
module tb_md_rx_source;

    localparam int DW   = 32;
    localparam int OW   = 2;
    localparam int SW   = 3;
    localparam int CW   = 4;
    localparam int CMAX = 15;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic [DW-1:0] req_data = '0;
    logic [OW-1:0] req_offset = '0;
    logic [SW-1:0] req_size = '0;
    logic          md_rx_valid;
    logic [DW-1:0] md_rx_data;
    logic [OW-1:0] md_rx_offset;
    logic [SW-1:0] md_rx_size;
    logic          md_rx_ready = 1'b0;
    logic          md_rx_err = 1'b0;
    logic          clr_cnt = 1'b0;
    logic [CW-1:0] xfer_cnt, err_cnt;
    logic          proto_viol, idle;

    always #5 clk = ~clk;

    md_rx_source #(.ALGN_DATA_WIDTH(DW), .FIFO_DEPTH(4), .CNT_W(CW)) dut (
        .clk(clk), .reset_n(reset_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_data(req_data),
        .req_offset(req_offset), .req_size(req_size),
        .md_rx_valid(md_rx_valid), .md_rx_data(md_rx_data),
        .md_rx_offset(md_rx_offset), .md_rx_size(md_rx_size),
        .md_rx_ready(md_rx_ready), .md_rx_err(md_rx_err), .clr_cnt(clr_cnt),
        .xfer_cnt(xfer_cnt), .err_cnt(err_cnt), .proto_viol(proto_viol), .idle(idle)
    );

    int tests = 0;
    int fails = 0;

    typedef struct packed {
        logic [DW-1:0] d;
        logic [OW-1:0] o;
        logic [SW-1:0] s;
    } tr_t;

    tr_t exp_q[$];
    int  m_x = 0, m_e = 0;
    bit  m_pv = 0;
    bit  have_prev = 0, p_v = 0, p_r = 0;
    tr_t p_t;

    // scoreboard: inputs are stable here until the next rising edge
    always @(negedge clk) begin
        tr_t cur, e;
        bit  done;
        cur = '{d: md_rx_data, o: md_rx_offset, s: md_rx_size};
        if (!reset_n) begin
            exp_q.delete();
            m_x = 0; m_e = 0; m_pv = 0; have_prev = 0;
        end else begin
            tests++;
            if (xfer_cnt !== CW'(m_x) || err_cnt !== CW'(m_e) || proto_viol !== m_pv) begin
                fails++;
                $display("FAIL stats: xfer/err/pv got %0d/%0d/%0b want %0d/%0d/%0b",
                         xfer_cnt, err_cnt, proto_viol, m_x, m_e, m_pv);
            end
            if (have_prev && p_v && !p_r) begin
                tests++;
                if (md_rx_valid !== 1'b1 || cur !== p_t) begin
                    fails++;
                    $display("FAIL hold: valid=%0b fields=%h want valid=1 fields=%h", md_rx_valid, cur, p_t);
                end
            end
            done = md_rx_valid && md_rx_ready;
            if (done) begin
                tests++;
                if (exp_q.size() == 0) begin
                    fails++;
                    $display("FAIL order: unexpected transfer %h, none queued", cur);
                end else begin
                    e = exp_q.pop_front();
                    if (cur !== e) begin
                        fails++;
                        $display("FAIL order: got %h want %h", cur, e);
                    end
                end
            end
            if (req_valid && req_ready) exp_q.push_back('{d: req_data, o: req_offset, s: req_size});
            if (clr_cnt) begin
                m_x = 0; m_e = 0; m_pv = 0;
            end else begin
                if (done) m_x = (m_x < CMAX) ? m_x + 1 : CMAX;
                if (done && md_rx_err) m_e = (m_e < CMAX) ? m_e + 1 : CMAX;
                if (md_rx_err && !done) m_pv = 1;
            end
            have_prev = 1; p_v = md_rx_valid; p_r = md_rx_ready; p_t = cur;
        end
    end

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic clear_counters();
        clr_cnt = 1'b1; tick(); clr_cnt = 1'b0;
    endtask

    // returns at a negedge where md_rx_valid is high, or got=0 after a budget
    task automatic wait_valid(output bit got);
        got = 0;
        for (int i = 0; i < 12 && !got; i++) begin
            @(negedge clk);
            if (md_rx_valid === 1'b1) got = 1;
            else tick();
        end
    endtask

    task automatic test_reset();
        #2;
        tests++;
        if (req_ready !== 1'b0 || md_rx_valid !== 1'b0 || md_rx_data !== '0 || md_rx_offset !== '0 ||
            md_rx_size !== '0 || xfer_cnt !== '0 || err_cnt !== '0 || proto_viol !== 1'b0 || idle !== 1'b1) begin
            fails++;
            $display("FAIL reset_state: rdy=%0b v=%0b d=%h o=%0d s=%0d x=%0d e=%0d pv=%0b idle=%0b want 0,0,0,0,0,0,0,0,1",
                     req_ready, md_rx_valid, md_rx_data, md_rx_offset, md_rx_size, xfer_cnt, err_cnt, proto_viol, idle);
        end
        #20 reset_n = 1'b1;          // t=22, between edges
        #1;
        tests++;
        if (req_ready !== 1'b0) begin
            fails++; $display("FAIL ready_before_edge: got %0b want 0", req_ready);
        end
        tick();
        tests++;
        if (req_ready !== 1'b1 || idle !== 1'b1) begin
            fails++; $display("FAIL ready_after_edge: rdy=%0b idle=%0b want 1,1", req_ready, idle);
        end
    endtask

    task automatic test_single();
        clear_counters();
        md_rx_ready = 1'b1;
        req_valid = 1'b1; req_data = 32'hDEADBEEF; req_offset = 2'd1; req_size = 3'd2;
        tick();                       // push edge N
        req_valid = 1'b0;
        @(negedge clk);
        tests++;
        if (md_rx_valid !== 1'b0) begin
            fails++; $display("FAIL single_early: valid got %0b want 0", md_rx_valid);
        end
        tick();                       // edge N+1 loads stage
        @(negedge clk);
        tests++;
        if (md_rx_valid !== 1'b1 || md_rx_data !== 32'hDEADBEEF || md_rx_offset !== 2'd1 || md_rx_size !== 3'd2) begin
            fails++;
            $display("FAIL single_out: v=%0b d=%h o=%0d s=%0d want 1 deadbeef 1 2",
                     md_rx_valid, md_rx_data, md_rx_offset, md_rx_size);
        end
        tick();                       // completion
        @(negedge clk);
        tests++;
        if (md_rx_valid !== 1'b0 || idle !== 1'b1 || xfer_cnt !== 4'd1 || err_cnt !== 4'd0) begin
            fails++;
            $display("FAIL single_done: v=%0b idle=%0b x=%0d e=%0d want 0 1 1 0", md_rx_valid, idle, xfer_cnt, err_cnt);
        end
        md_rx_ready = 1'b0;
        tick();
    endtask

    task automatic test_stall();
        bit got;
        clear_counters();
        md_rx_ready = 1'b0;
        req_valid = 1'b1; req_data = $urandom; req_offset = 2'd1; req_size = 3'd2;
        tick();
        req_valid = 1'b0;
        wait_valid(got);
        tests++;
        if (!got) begin fails++; $display("FAIL stall_timeout: valid got 0 want 1"); end
        for (int i = 0; i < 5; i++) begin
            tick();
            @(negedge clk);
            tests++;
            if (md_rx_valid !== 1'b1 || md_rx_data !== req_data || md_rx_offset !== 2'd1 || md_rx_size !== 3'd2) begin
                fails++;
                $display("FAIL stall_hold%0d: v=%0b d=%h want 1 %h", i, md_rx_valid, md_rx_data, req_data);
            end
        end
        tick();
        md_rx_ready = 1'b1;
        tick();
        md_rx_ready = 1'b0;
        @(negedge clk);
        tests++;
        if (md_rx_valid !== 1'b0 || xfer_cnt !== 4'd1) begin
            fails++; $display("FAIL stall_done: v=%0b x=%0d want 0 1", md_rx_valid, xfer_cnt);
        end
        tick();
    endtask

    task automatic test_fill();
        int acc = 0;
        clear_counters();
        md_rx_ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            req_valid = 1'b1; req_data = 32'hA000_0000 + i;
            req_offset = OW'($urandom_range(0, 3)); req_size = SW'($urandom_range(0, 4));
            @(negedge clk);
            if (req_ready) acc++;
            tick();
        end
        req_valid = 1'b0;
        tests++;
        if (acc != 5 || req_ready !== 1'b0) begin
            fails++; $display("FAIL fill_capacity: accepted=%0d rdy=%0b want 5 0", acc, req_ready);
        end
        md_rx_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            tests++;
            if (md_rx_valid !== 1'b1) begin
                fails++; $display("FAIL drain_gap%0d: valid got 0 want 1", i);
            end
            tick();
        end
        @(negedge clk);
        tests++;
        if (md_rx_valid !== 1'b0 || idle !== 1'b1 || xfer_cnt !== 4'd5) begin
            fails++; $display("FAIL drain_done: v=%0b idle=%0b x=%0d want 0 1 5", md_rx_valid, idle, xfer_cnt);
        end
        md_rx_ready = 1'b0;
        tick();
    endtask

    task automatic test_err();
        bit got;
        clear_counters();
        md_rx_ready = 1'b0;
        req_valid = 1'b1; req_data = $urandom; req_offset = 2'd3; req_size = 3'd2;
        tick();
        req_valid = 1'b0;
        wait_valid(got);
        tests++;
        if (!got) begin fails++; $display("FAIL err_timeout: valid got 0 want 1"); end
        tick();
        md_rx_ready = 1'b1; md_rx_err = 1'b1;   // error on a completion
        tick();
        md_rx_ready = 1'b0;                     // error while idle
        tick();
        md_rx_err = 1'b0;
        @(negedge clk);
        tests++;
        if (xfer_cnt !== 4'd1 || err_cnt !== 4'd1 || proto_viol !== 1'b1) begin
            fails++; $display("FAIL err_stats: x=%0d e=%0d pv=%0b want 1 1 1", xfer_cnt, err_cnt, proto_viol);
        end
        tick();
        clear_counters();
        @(negedge clk);
        tests++;
        if (xfer_cnt !== 4'd0 || err_cnt !== 4'd0 || proto_viol !== 1'b0) begin
            fails++; $display("FAIL err_clear: x=%0d e=%0d pv=%0b want 0 0 0", xfer_cnt, err_cnt, proto_viol);
        end
        tick();
    endtask

    task automatic test_saturate();
        int acc = 0;
        bit gone = 0;
        clear_counters();
        md_rx_ready = 1'b1;
        for (int i = 0; i < 100 && acc < 17; i++) begin
            req_valid = 1'b1; req_data = $urandom;
            req_offset = OW'($urandom_range(0, 3)); req_size = SW'($urandom_range(1, 4));
            @(negedge clk);
            if (req_ready) acc++;
            tick();
        end
        req_valid = 1'b0;
        for (int i = 0; i < 20 && !gone; i++) begin
            @(negedge clk);
            if (idle === 1'b1) gone = 1; else tick();
        end
        tests++;
        if (acc != 17 || !gone || xfer_cnt !== 4'd15) begin
            fails++; $display("FAIL saturate: pushed=%0d idle=%0b x=%0d want 17 1 15", acc, gone, xfer_cnt);
        end
        tick();
        req_valid = 1'b1; req_data = $urandom;
        tick();                       // push edge N
        req_valid = 1'b0;
        tick();                       // stage loads at N+1
        clr_cnt = 1'b1;               // completion and clear share edge N+2
        @(negedge clk);
        tests++;
        if (md_rx_valid !== 1'b1) begin
            fails++; $display("FAIL clr_setup: valid got %0b want 1", md_rx_valid);
        end
        tick();
        clr_cnt = 1'b0;
        @(negedge clk);
        tests++;
        if (xfer_cnt !== 4'd0 || md_rx_valid !== 1'b0) begin
            fails++; $display("FAIL clr_priority: x=%0d v=%0b want 0 0", xfer_cnt, md_rx_valid);
        end
        md_rx_ready = 1'b0;
        tick();
    endtask

    task automatic test_reset_mid();
        bit stale = 0;
        clear_counters();
        md_rx_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            req_valid = 1'b1; req_data = 32'hC000_0000 + i;
            tick();
        end
        req_valid = 1'b0;
        @(posedge clk); #3;
        reset_n = 1'b0;
        #1;
        tests++;
        if (md_rx_valid !== 1'b0 || idle !== 1'b1 || req_ready !== 1'b0) begin
            fails++; $display("FAIL async_reset: v=%0b idle=%0b rdy=%0b want 0 1 0", md_rx_valid, idle, req_ready);
        end
        @(posedge clk); #3;
        reset_n = 1'b1;
        md_rx_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (md_rx_valid !== 1'b0) stale = 1;
            tick();
        end
        tests++;
        if (stale || idle !== 1'b1 || xfer_cnt !== 4'd0) begin
            fails++; $display("FAIL stale_after_reset: stale=%0b idle=%0b x=%0d want 0 1 0", stale, idle, xfer_cnt);
        end
        md_rx_ready = 1'b0;
    endtask

    task automatic test_random();
        bit gone = 0;
        clear_counters();
        for (int i = 0; i < 400; i++) begin
            req_valid   = 1'($urandom_range(0, 1));
            req_data    = $urandom;
            req_offset  = OW'($urandom_range(0, 3));
            req_size    = SW'($urandom_range(0, 7));
            md_rx_ready = ($urandom_range(0, 9) < 6);
            md_rx_err   = ($urandom_range(0, 9) == 0);
            clr_cnt     = ($urandom_range(0, 59) == 0);
            tick();
        end
        req_valid = 1'b0; md_rx_err = 1'b0; clr_cnt = 1'b0; md_rx_ready = 1'b1;
        for (int i = 0; i < 20 && !gone; i++) begin
            @(negedge clk);
            if (idle === 1'b1) gone = 1; else tick();
        end
        tick();
        tests++;
        if (!gone || exp_q.size() != 0) begin
            fails++; $display("FAIL random_drain: idle=%0b leftover=%0d want 1 0", gone, exp_q.size());
        end
        md_rx_ready = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single();
        test_stall();
        test_fill();
        test_err();
        test_saturate();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

endmodule

// File: doc/md_rx_source.md
Name: md_rx_source

Overview:
- MD-protocol initiator that drives the aligner's MD RX port.
- Buffers transfer requests from an upstream push interface in a small FIFO.
- Presents each request on MD RX with valid/field hold-until-ready semantics.
- Samples md_rx_err on every completed transfer and keeps transfer/error statistics for the bench and the register block.

Parameters:
- ALGN_DATA_WIDTH, 32: MD data bus width in bits (multiple of 8).
- BUS_BYTES, ALGN_DATA_WIDTH/8: bytes per bus word.
- OFFSET_W, (BUS_BYTES>1)?$clog2(BUS_BYTES):1: width of the offset field.
- SIZE_W, $clog2(BUS_BYTES)+1: width of the size field.
- FIFO_DEPTH, 4: request FIFO entries; power of two, at least 2.
- CNT_W, 16: width of the statistics counters.

Ports:
- clk  in  1  clock, all logic on rising edge.
- reset_n  in  1  asynchronous active-low reset.
- req_valid  in  1  upstream request valid.
- req_ready  out  1  upstream request accepted when high together with req_valid.
- req_data  in  ALGN_DATA_WIDTH  request data.
- req_offset  in  OFFSET_W  request byte offset.
- req_size  in  SIZE_W  request byte count.
- md_rx_valid  out  1  MD transfer valid.
- md_rx_data  out  ALGN_DATA_WIDTH  MD data.
- md_rx_offset  out  OFFSET_W  MD offset.
- md_rx_size  out  SIZE_W  MD size.
- md_rx_ready  in  1  MD responder ready.
- md_rx_err  in  1  MD responder error, meaningful only on a completed transfer.
- clr_cnt  in  1  synchronous clear of the counters and the sticky flag.
- xfer_cnt  out  CNT_W  completed transfers, saturating.
- err_cnt  out  CNT_W  completed transfers with md_rx_err=1, saturating.
- proto_viol  out  1  sticky: md_rx_err seen without a completed transfer.
- idle  out  1  FIFO empty and md_rx_valid low.

Behaviour:
- Reset (asynchronous, reset_n=0):
  - FIFO empty, output stage empty.
  - md_rx_valid=0; md_rx_data, md_rx_offset and md_rx_size =0.
  - Counters =0, proto_viol=0, idle=1.
  - req_ready=0 while reset_n=0 and =1 from the first edge after release.
  - Reset mid-transfer drops the pending transfer and all queued requests without completing them.
- Push:
  - req_ready = !fifo_full, a registered-state function.
  - A push occurs when req_valid && req_ready.
  - A push is not accepted when the FIFO is full, even if a pop happens in the same cycle.
- Output stage: a single register holding md_rx_valid and the three fields. It loads from the FIFO head when the stage is empty, or when the current transfer completes this cycle and the FIFO is non-empty.
- Bypass: the FIFO may be bypassed. Latency from push at edge N into an empty block to md_rx_valid=1 is exactly one cycle (valid high after edge N+1).
- Completion: a transfer completes on an edge where md_rx_valid && md_rx_ready.
  - If the FIFO is non-empty, the next entry loads on that same edge and md_rx_valid stays 1, giving back-to-back transfers of one per cycle.
  - Otherwise md_rx_valid falls to 0.
- Hold rule: while md_rx_valid=1 and md_rx_ready=0, md_rx_valid stays 1 and data/offset/size are bit-identical to the previous cycle. md_rx_valid never falls without a completion.
- Fields are forwarded unmodified; the block does not check legality. size=0 and offset+size>BUS_BYTES are legal stimuli for provoking md_rx_err.
- Completion counting:
  - xfer_cnt increments by 1 per completion.
  - err_cnt increments when md_rx_err=1 at completion.
  - Both saturate at 2^CNT_W-1 with no wrap.
- proto_viol is set when md_rx_err=1 and !(md_rx_valid && md_rx_ready). It stays set until clr_cnt or reset.
- clr_cnt=1 zeroes xfer_cnt, err_cnt and proto_viol on the next edge. It has priority over a same-cycle increment (result 0). It does not affect the FIFO or the output stage.
- FIFO pointers wrap modulo FIFO_DEPTH. Full and empty are distinguished by an extra pointer bit or an occupancy count.
- Total capacity is FIFO_DEPTH+1 outstanding requests (FIFO plus output stage).
- idle=1 iff FIFO empty && md_rx_valid=0.

Test Plan:
- Single request data=0xDEADBEEF, offset=1, size=2 pushed with md_rx_ready=1 -> md_rx_valid high one cycle after push with those exact fields; completes next edge; xfer_cnt=1, err_cnt=0, idle returns to 1.
- Same request with md_rx_ready held 0 for 5 cycles, then 1 -> valid and fields constant all 5 cycles; one completion; xfer_cnt=1.
- 6 pushes back-to-back with md_rx_ready=0 (FIFO_DEPTH=4) -> req_ready drops after 5 accepted; then md_rx_ready=1 drains 5 transfers on 5 consecutive cycles in push order; xfer_cnt=5.
- Transfers offset=3, size=2 with md_rx_err=1 at completion, and md_rx_err=1 pulsed while md_rx_valid=0 -> err_cnt=1, proto_viol=1; clr_cnt -> all counters 0, proto_viol=0.
- Preload xfer_cnt near saturation (CNT_W=4 build, 17 transfers) -> xfer_cnt stops at 15; clr_cnt in the same cycle as a completion -> 0.
- reset_n asserted asynchronously mid-stall with 3 queued requests -> md_rx_valid=0 immediately; after release idle=1 and no stale transfer appears.
